// File: rtl/pipe_stage_pkg.sv
// Shared pipeline-register definitions: control levels,
// per-stage payload bundles and their widths.
package pipe_stage_pkg;

    localparam logic PipeFlush = 1'b1;
    localparam logic PipeStall = 1'b1;

    localparam int InstBusW    = 32;
    localparam int AluOpBusW   = 8;
    localparam int AluSelBusW  = 3;
    localparam int RegBusW     = 32;
    localparam int RegAddrBusW = 5;

    typedef struct packed {
        logic [RegBusW-1:0]  pc;
        logic [InstBusW-1:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [AluOpBusW-1:0]   aluop;
        logic [AluSelBusW-1:0]  alusel;
        logic [RegBusW-1:0]     reg1;
        logic [RegBusW-1:0]     reg2;
        logic [RegAddrBusW-1:0] wd;
        logic                   wreg;
    } id_ex_t;

    typedef struct packed {
        logic [RegAddrBusW-1:0] wd;
        logic                   wreg;
        logic [RegBusW-1:0]     wdata;
    } ex_mem_t;

    typedef ex_mem_t mem_wb_t;

    localparam int IfIdW  = $bits(if_id_t);
    localparam int IdExW  = $bits(id_ex_t);
    localparam int ExMemW = $bits(ex_mem_t);
    localparam int MemWbW = $bits(mem_wb_t);

    function automatic logic [1:0] entry_count(logic a, logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready payload link between two pipeline stages.
// master drives valid/data, slave drives ready.
interface pipe_stage_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage.sv
// Parametrised pipeline stage register with stall/flush and
// an optional 2-entry skid buffer for a registered upstream ready.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              SKID     = 1,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        stall_i,
    pipe_stage_if.slave  up_if,
    pipe_stage_if.master dn_if,
    output logic [1:0]  count_o
);

    logic              flush;
    logic              stall;
    logic              push;
    logic              pop;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;

    assign flush = (flush_i == PipeFlush);
    assign stall = (stall_i == PipeStall);

    assign pop  = main_valid & dn_if.ready & ~stall;
    assign push = up_if.valid & up_if.ready;

    assign dn_if.valid = main_valid;
    assign dn_if.data  = main_data;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic              ready_q;
            logic              mv_n;
            logic              sv_n;
            logic [DATA_W-1:0] md_n;
            logic [DATA_W-1:0] sd_n;

            assign up_if.ready = ready_q;
            assign count_o     = entry_count(main_valid, skid_valid);

            // Next-state of the two entries; main is always presented.
            always_comb begin
                mv_n = main_valid;
                md_n = main_data;
                sv_n = skid_valid;
                sd_n = skid_data;
                if (flush) begin
                    mv_n = 1'b0;
                    md_n = RST_DATA;
                    sv_n = 1'b0;
                    sd_n = RST_DATA;
                end else if (pop) begin
                    if (skid_valid) begin
                        mv_n = 1'b1;
                        md_n = skid_data;
                        sv_n = 1'b0;
                        sd_n = RST_DATA;
                    end else if (push) begin
                        md_n = up_if.data;
                    end else begin
                        mv_n = 1'b0;
                        md_n = RST_DATA;
                    end
                end else if (push) begin
                    if (!main_valid) begin
                        mv_n = 1'b1;
                        md_n = up_if.data;
                    end else begin
                        sv_n = 1'b1;
                        sd_n = up_if.data;
                    end
                end
            end

            // Entry registers; ready is the registered inverse of skid occupancy.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_valid <= 1'b0;
                    main_data  <= RST_DATA;
                    skid_valid <= 1'b0;
                    skid_data  <= RST_DATA;
                    ready_q    <= 1'b1;
                end else begin
                    main_valid <= mv_n;
                    main_data  <= md_n;
                    skid_valid <= sv_n;
                    skid_data  <= sd_n;
                    ready_q    <= ~sv_n;
                end
            end
        end else begin : g_single
            assign up_if.ready = ~main_valid | (dn_if.ready & ~stall);
            assign count_o     = entry_count(main_valid, 1'b0);

            // Single entry: a push replaces main, a lone pop empties it.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_valid <= 1'b0;
                    main_data  <= RST_DATA;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_data  <= RST_DATA;
                end else if (push) begin
                    main_valid <= 1'b1;
                    main_data  <= up_if.data;
                end else if (pop) begin
                    main_valid <= 1'b0;
                    main_data  <= RST_DATA;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: one SKID=1 and one SKID=0
// instance share stimulus; each has its own expected-data queue.
module tb_pipe_stage;

    localparam logic [31:0] RST = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic [1:0]  cnt1;
    logic [1:0]  cnt0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q1[$];
    logic [31:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_if #(.DATA_W(32)) u1_up ();
    pipe_stage_if #(.DATA_W(32)) u1_dn ();
    pipe_stage_if #(.DATA_W(32)) u0_up ();
    pipe_stage_if #(.DATA_W(32)) u0_dn ();

    assign u1_up.valid = in_valid;
    assign u1_up.data  = in_data;
    assign u1_dn.ready = out_ready;
    assign u0_up.valid = in_valid;
    assign u0_up.data  = in_data;
    assign u0_dn.ready = out_ready;

    pipe_stage #(.DATA_W(32), .SKID(1), .RST_DATA(RST)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .stall_i (stall),
        .up_if   (u1_up),
        .dn_if   (u1_dn),
        .count_o (cnt1)
    );

    pipe_stage #(.DATA_W(32), .SKID(0), .RST_DATA(RST)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .stall_i (stall),
        .up_if   (u0_up),
        .dn_if   (u0_dn),
        .count_o (cnt0)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for SKID=1: compare pops, then record accepted pushes.
    always @(negedge clk) begin
        if (rst) begin
            if (u1_dn.valid && out_ready && !stall) begin
                if (q1.size() == 0) begin
                    chk("s1_unexpected_out", u1_dn.data, 32'hxxxxxxxx);
                end else begin
                    chk("s1_out_data", u1_dn.data, q1.pop_front());
                end
            end
            if (!u1_dn.valid) chk("s1_idle_data", u1_dn.data, RST);
            if (flush) q1.delete();
            else if (in_valid && u1_up.ready) q1.push_back(in_data);
        end
    end

    // Monitor for SKID=0: same scoreboard discipline.
    always @(negedge clk) begin
        if (rst) begin
            if (u0_dn.valid && out_ready && !stall) begin
                if (q0.size() == 0) begin
                    chk("s0_unexpected_out", u0_dn.data, 32'hxxxxxxxx);
                end else begin
                    chk("s0_out_data", u0_dn.data, q0.pop_front());
                end
            end
            if (!u0_dn.valid) chk("s0_idle_data", u0_dn.data, RST);
            if (flush) q0.delete();
            else if (in_valid && u0_up.ready) q0.push_back(in_data);
        end
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b0;

        // reset held with traffic offered
        repeat (3) begin
            step();
            chk("rst_s1_valid", {31'b0, u1_dn.valid}, 32'd0);
            chk("rst_s1_data", u1_dn.data, RST);
            chk("rst_s1_count", {30'b0, cnt1}, 32'd0);
            chk("rst_s1_ready", {31'b0, u1_up.ready}, 32'd1);
            chk("rst_s0_ready", {31'b0, u0_up.ready}, 32'd1);
            chk("rst_s0_count", {30'b0, cnt0}, 32'd0);
        end

        // first push after release, then streaming 2..4
        rst       = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h1;
        step();
        chk("first_s1_valid", {31'b0, u1_dn.valid}, 32'd1);
        chk("first_s1_data", u1_dn.data, 32'h1);
        for (int i = 2; i <= 4; i++) begin
            in_data = i;
            step();
            chk("stream_s1_data", u1_dn.data, i);
            chk("stream_s1_count", {30'b0, cnt1}, 32'd1);
            chk("stream_s1_ready", {31'b0, u1_up.ready}, 32'd1);
            chk("stream_s0_data", u0_dn.data, i);
        end
        in_valid = 1'b0;
        step();
        chk("drain_s1_count", {30'b0, cnt1}, 32'd0);

        // backpressure: A, B, C with downstream blocked
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        chk("bp_a_count", {30'b0, cnt1}, 32'd1);
        chk("bp_a_ready", {31'b0, u1_up.ready}, 32'd1);
        in_data = 32'hB;
        step();
        chk("bp_b_count", {30'b0, cnt1}, 32'd2);
        chk("bp_b_ready", {31'b0, u1_up.ready}, 32'd0);
        in_data = 32'hC;
        step();
        chk("bp_c_count", {30'b0, cnt1}, 32'd2);
        chk("bp_c_head", u1_dn.data, 32'hA);
        chk("bp_s0_head", u0_dn.data, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_rel_head", u1_dn.data, 32'hB);
        chk("bp_rel_count", {30'b0, cnt1}, 32'd1);
        step();
        chk("bp_c_head2", u1_dn.data, 32'hC);
        in_valid = 1'b0;
        step();
        step();
        chk("bp_empty", {30'b0, cnt1}, 32'd0);

        // stall holds the presented entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        step();
        in_valid  = 1'b0;
        stall     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            step();
            chk("stall_s1_data", u1_dn.data, 32'h55);
            chk("stall_s1_valid", {31'b0, u1_dn.valid}, 32'd1);
            chk("stall_s0_data", u0_dn.data, 32'h55);
        end
        stall = 1'b0;
        step();
        chk("stall_pop_valid", {31'b0, u1_dn.valid}, 32'd0);
        step();

        // flush while full, with a push of Z offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        chk("fl_pre_count", {30'b0, cnt1}, 32'd2);
        flush   = 1'b1;
        in_data = 32'h33;
        step();
        chk("fl_s1_count", {30'b0, cnt1}, 32'd0);
        chk("fl_s1_valid", {31'b0, u1_dn.valid}, 32'd0);
        chk("fl_s1_data", u1_dn.data, RST);
        chk("fl_s1_ready", {31'b0, u1_up.ready}, 32'd1);
        chk("fl_s0_count", {30'b0, cnt0}, 32'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // SKID=0 replace: push 8 while 7 pops
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h7;
        step();
        out_ready = 1'b1;
        in_data   = 32'h8;
        #1;
        chk("rep_s0_ready", {31'b0, u0_up.ready}, 32'd1);
        step();
        chk("rep_s0_data", u0_dn.data, 32'h8);
        chk("rep_s0_count", {30'b0, cnt0}, 32'd1);
        chk("rep_s1_data", u1_dn.data, 32'h8);
        in_valid = 1'b0;
        repeat (3) step();

        chk("end_q1_empty", q1.size(), 32'd0);
        chk("end_q0_empty", q0.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
- Parametrised pipeline stage register, the successor to the fixed if_id / id_ex / ex_mem / mem_wb latches of the core.
- Carries an opaque DATA_W payload between two pipeline stages with a valid/ready handshake.
- Adds stall and flush control from the pipeline controller, plus an optional 2-entry skid buffer so the upstream ready is registered.
- One instance sits between each pair of stages; the ID_EX payload bundles aluop, alusel, reg1, reg2, wd and wreg.

Parameters:
- DATA_W, 32: payload width in bits, >=1.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready_o; 0 = single register with combinational in_ready_o.
- RST_DATA, 0: value of data_o whenever the stage is empty, after reset and after flush (NOP encoding).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; discards all held entries.
- stall_i  in  1  freeze the output side; no output transfer this cycle.
- in_valid_i  in  1  upstream presents data.
- in_data_i  in  DATA_W  upstream payload.
- in_ready_o  out  1  stage can accept this cycle.
- out_valid_o  out  1  stage presents data downstream.
- out_data_o  out  DATA_W  downstream payload.
- out_ready_i  in  1  downstream accepts.
- count_o  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (rst low, asynchronous):
  - Entries are cleared: out_valid_o=0, out_data_o=RST_DATA, count_o=0.
  - in_ready_o=1 in both modes.
  - Normal operation resumes on the first rising edge after rst deasserts.
  - Reset mid-transfer drops all held data; no partial state survives.
- Transfer definitions:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i & ~stall_i.
  - stall_i only masks pop. It does not directly gate in_ready_o in SKID=1 mode.
- Latency: 1 cycle. Data pushed at edge N is on out_data_o with out_valid_o=1 after edge N. There is no combinational path from in_data_i to out_data_o.
- out_data_o equals RST_DATA whenever out_valid_o=0. The entry register is loaded with RST_DATA when it empties.
- SKID=0:
  - in_ready_o = ~main_valid | (out_ready_i & ~stall_i), combinational.
  - Simultaneous push and pop replaces main with the new data; count stays 1.
- SKID=1 (entries: main, skid; main is always the one presented):
  - in_ready_o = ~skid_valid, registered, with no combinational dependence on out_ready_i.
  - Push with main empty, or with main popping and skid empty: write main.
  - Push with main full and not popping: write skid. count goes 1 -> 2 and in_ready_o falls next cycle.
  - Pop with skid full: skid moves to main and skid clears. If a push coincides, it is impossible, because in_ready_o=0.
  - Pop with skid empty and no push: main clears and count goes 1 -> 0.
  - Order is strictly FIFO; no entry is ever duplicated or lost.
- Full/empty:
  - Full (count=2): in_ready_o=0; upstream data is held by upstream.
  - Empty: out_valid_o=0; out_ready_i is ignored.
- Flush (synchronous, highest priority):
  - On an edge with flush_i=1, both entries clear: count=0, out_valid_o=0, data=RST_DATA.
  - A push offered in the same cycle is dropped, even if in_ready_o=1. A pop in the same cycle is still counted as delivered downstream.
  - Flush has priority over stall.
- Stall:
  - stall_i=1 holds out_data_o and out_valid_o stable.
  - In SKID=1, pushes continue until full.
  - In SKID=0, a push is accepted only if main is empty.
- Width rules: the payload is opaque and copied bit-exactly; no arithmetic is applied to it. count_o saturates logically at 2 and cannot overflow.

Decomposition:
- Shared package / defines.v additions:
  - PipeFlush, PipeStall (1'b1 asserted levels).
  - The per-stage payload widths: `IfIdW, `IdExW, `ExMemW, `MemWbW, built from the existing `InstBus, `AluOpBus, `AluSelBus, `RegBus and `RegAddrBus widths.
- No sub-module. The skid logic is a generate branch on SKID inside pipe_stage.
- The core later instantiates four pipe_stage instances with the widths above.

Test Plan:
- Reset: hold rst low 3 cycles with in_valid_i=1 and in_data_i=32'hDEADBEEF -> out_valid_o=0, out_data_o=0, count_o=0, in_ready_o=1; after release, first push 32'h1 appears after 1 edge.
- Streaming: out_ready_i=1, push 1,2,3,4 on consecutive cycles -> outputs 1,2,3,4 on consecutive cycles; count_o stays 1; in_ready_o stays 1.
- Backpressure SKID=1: push A,B,C with out_ready_i=0 -> A and B accepted, count_o=2, in_ready_o=0 from the cycle after B, C held upstream; raise out_ready_i -> A, B, C delivered in order, none lost.
- Stall: main=32'h55, stall_i=1 for 4 cycles with out_ready_i=1 -> out_data_o stays 32'h55 and is popped exactly once after stall_i drops.
- Flush: count_o=2 holding X,Y, assert flush_i with push Z in the same cycle -> next cycle count_o=0, out_valid_o=0, out_data_o=RST_DATA, and Z is never output.
- SKID=0 replace: main=7, push 8 in the same cycle as a pop of 7 -> next cycle out_data_o=8, count_o=1, and in_ready_o was 1 in that cycle.
